// File: rtl/add36_share_arb.sv
// add36_share_arb: round-robin sequencer that time-shares one 36-bit adder
// among NREQ requesters. Each transaction goes through IDLE (grant and operand
// capture), EXEC (shared add) and RESP (hold result until the consumer takes it).
//
// Optional feature: define ADD36_ARB_CARRY_EN to add the registered rsp_carry
// output. The carry is rebuilt from the operand and sum MSBs, so the shared
// adder stays 36 bits wide.
module add36_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int W    = 36
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*W-1:0]    req_a,
    input  logic [NREQ*W-1:0]    req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [W-1:0]         rsp_sum,
    output logic [IDW-1:0]       rsp_id,
`ifdef ADD36_ARB_CARRY_EN
    output logic                 rsp_carry,
`endif
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Shared adder: plain unsigned add, wraps modulo 2^W.
    function automatic logic [W-1:0] adder36(input logic [W-1:0] a, input logic [W-1:0] b);
        return a + b;
    endfunction

`ifdef ADD36_ARB_CARRY_EN
    // Carry-out recovered from the MSBs: both set, or exactly one set and the sum MSB cleared.
    function automatic logic carry36(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [W-1:0] s);
        return (a[W-1] & b[W-1]) | ((a[W-1] ^ b[W-1]) & ~s[W-1]);
    endfunction
`endif

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [W-1:0]     op_a_q, op_a_d;
    logic [W-1:0]     op_b_q, op_b_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [W-1:0]     rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
`ifdef ADD36_ARB_CARRY_EN
    logic             rsp_carry_q, rsp_carry_d;
`endif

    logic             grant_found_s;
    logic [IDW-1:0]   grant_idx_s;
    logic [IDW-1:0]   cand_s;
    logic [NREQ-1:0]  req_ready_s;
    logic [W-1:0]     sum_s;

    // The single shared adder always sees the captured operands.
    assign sum_s = adder36(op_a_q, op_b_q);

    // Round-robin scan: first valid requester after last_grant (wrapping) wins.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = IDW'((int'(last_grant_q) + k) % NREQ);
            if (!grant_found_s && req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Next-state and datapath update; req_ready is only ever raised in IDLE.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_id_d     = rsp_id_q;
`ifdef ADD36_ARB_CARRY_EN
        rsp_carry_d  = rsp_carry_q;
`endif
        req_ready_s  = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_found_s) begin
                    req_ready_s[grant_idx_s] = 1'b1;
                    op_a_d  = req_a[grant_idx_s*W +: W];
                    op_b_d  = req_b[grant_idx_s*W +: W];
                    id_d    = grant_idx_s;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                rsp_sum_d   = sum_s;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
`ifdef ADD36_ARB_CARRY_EN
                rsp_carry_d = carry36(op_a_q, op_b_q, sum_s);
`endif
                state_d     = S_RESP;
            end
            S_RESP: begin
                // Pointer moves only when the result is taken, so fairness
                // follows completed transactions, not grants.
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    last_grant_d = rsp_id_q;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            op_a_q       <= '0;
            op_b_q       <= '0;
            id_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_sum_q    <= '0;
            rsp_id_q     <= '0;
`ifdef ADD36_ARB_CARRY_EN
            rsp_carry_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_id_q     <= rsp_id_d;
`ifdef ADD36_ARB_CARRY_EN
            rsp_carry_q  <= rsp_carry_d;
`endif
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != S_IDLE);
`ifdef ADD36_ARB_CARRY_EN
    assign rsp_carry = rsp_carry_q;
`endif

endmodule

// File: tb/tb_add36_share_arb.sv
// Self-checking bench for add36_share_arb: a transaction-level model (one
// outstanding transaction, response due two cycles after acceptance) is
// compared against the DUT every cycle, plus directed literal checks.
module tb_add36_share_arb;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = 36;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [W-1:0]        rsp_sum;
    logic [IDW-1:0]      rsp_id;
    logic                busy;
`ifdef ADD36_ARB_CARRY_EN
    logic                rsp_carry;
`endif

    logic [W-1:0] a_v [NREQ];
    logic [W-1:0] b_v [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = a_v[i];
            req_b[i*W +: W] = b_v[i];
        end
    end

    add36_share_arb #(.NREQ(NREQ), .IDW(IDW), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
`ifdef ADD36_ARB_CARRY_EN
        .rsp_carry (rsp_carry),
`endif
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit        m_on  = 1'b0;
    bit        m_out = 1'b0;
    int        m_acc = 0;
    int        m_ptr = NREQ - 1;
    int        m_id  = 0;
    logic [W:0] m_full = '0;
    int        cyc   = 0;
    int        resp_count = 0;
    int        grant_log [$];
    int        grant_cyc [$];

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (ptr + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : cmp
        int pick;
        logic exp_v;
        logic [NREQ-1:0] exp_rdy;
        pick    = rr_pick(req_valid, m_ptr);
        exp_v   = m_out && (cyc >= m_acc + 2);
        exp_rdy = '0;
        if (!m_out && pick >= 0) exp_rdy[pick] = 1'b1;
        if (m_on) begin
            check("req_ready", req_ready, exp_rdy);
            check("rsp_valid", rsp_valid, exp_v);
            check("busy", busy, m_out);
            if (exp_v) begin
                check("rsp_sum", rsp_sum, m_full[W-1:0]);
                check("rsp_id", rsp_id, m_id);
`ifdef ADD36_ARB_CARRY_EN
                check("rsp_carry", rsp_carry, m_full[W]);
`endif
            end
        end
        if (rst) begin
            m_on  = 1'b1;
            m_out = 1'b0;
            m_ptr = NREQ - 1;
        end else if (!m_out) begin
            if (pick >= 0) begin
                m_out  = 1'b1;
                m_acc  = cyc;
                m_id   = pick;
                m_full = {1'b0, a_v[pick]} + {1'b0, b_v[pick]};
                grant_log.push_back(pick);
                grant_cyc.push_back(cyc);
            end
        end else if (exp_v && rsp_ready) begin
            m_out = 1'b0;
            m_ptr = m_id;
            resp_count++;
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input int i, input int limit, input string name);
        bit ok = 1'b0;
        for (int c = 0; c < limit && !ok; c++) begin
            #1;
            if (req_ready[i] && req_valid[i]) ok = 1'b1;
            tick();
        end
        check(name, ok, 1'b1);
    endtask

    task automatic wait_rsp(input int limit, input string name);
        bit ok = 1'b0;
        for (int c = 0; c < limit && !ok; c++) begin
            #1;
            if (rsp_valid) ok = 1'b1;
            else tick();
        end
        check(name, ok, 1'b1);
    endtask

    function automatic logic [W-1:0] rnd36();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        if ($urandom_range(0, 9) == 0) r = '1;
        return r[W-1:0];
    endfunction

    initial begin
        int base;
        int n0;
        logic [W-1:0] exp_s;
        logic [NREQ-1:0] hs;
        bit seen1;

        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin a_v[i] = '0; b_v[i] = '0; end
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("reset rsp_valid", rsp_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset rsp_sum", rsp_sum, 36'h0);
        check("reset rsp_id", rsp_id, 2'd0);
        check("reset req_ready", req_ready, 4'b0000);
        tick();

        // Single request from requester 2
        a_v[2] = 36'h5; b_v[2] = 36'h3; req_valid = 4'b0100; rsp_ready = 1'b1;
        #1;
        check("single ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        #1;
        check("single exec valid", rsp_valid, 1'b0);
        tick();
        #1;
        check("single rsp_valid", rsp_valid, 1'b1);
        check("single rsp_sum", rsp_sum, 36'h8);
        check("single rsp_id", rsp_id, 2'd2);
        tick();
        check("single done", rsp_valid, 1'b0);

        // All requesters continuously valid after reset: 0,1,2,3,0 three cycles apart
        rst = 1'b1; tick(); rst = 1'b0;
        base = grant_log.size();
        for (int i = 0; i < NREQ; i++) begin a_v[i] = rnd36(); b_v[i] = rnd36(); end
        req_valid = 4'hF; rsp_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            #1;
            hs = req_valid & req_ready;
            check("rr onehot0", $onehot0(req_ready), 1'b1);
            tick();
            for (int i = 0; i < NREQ; i++) if (hs[i]) begin a_v[i] = rnd36(); b_v[i] = rnd36(); end
        end
        req_valid = '0;
        repeat (3) tick();
        check("rr grant count", grant_log.size() - base, 5);
        if (grant_log.size() >= base + 5) begin
            for (int k = 0; k < 5; k++) check("rr grant order", grant_log[base + k], k % NREQ);
            for (int k = 1; k < 5; k++)
                check("rr grant spacing", grant_cyc[base + k] - grant_cyc[base + k - 1], 3);
        end

        // Backpressure: hold the result 5 cycles while others request
        a_v[1] = rnd36(); b_v[1] = rnd36(); exp_s = a_v[1] + b_v[1];
        req_valid = 4'b0010; rsp_ready = 1'b0;
        wait_accept(1, 8, "bp accept timeout");
        req_valid = 4'hF;
        wait_rsp(8, "bp rsp timeout");
        n0 = resp_count;
        for (int c = 0; c < 5; c++) begin
            check("bp rsp_valid", rsp_valid, 1'b1);
            check("bp rsp_sum", rsp_sum, exp_s);
            check("bp rsp_id", rsp_id, 2'd1);
            check("bp req_ready", req_ready, 4'b0000);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        #1;
        check("bp release", rsp_valid, 1'b0);
        check("bp single accept", resp_count - n0, 1);
        repeat (2) tick();

        // Wrap-around
        a_v[0] = 36'hF_FFFF_FFFF; b_v[0] = 36'h0_0000_0001;
        req_valid = 4'b0001;
        wait_accept(0, 8, "wrap accept timeout");
        req_valid = '0;
        wait_rsp(8, "wrap rsp timeout");
        check("wrap rsp_sum", rsp_sum, 36'h0);
`ifdef ADD36_ARB_CARRY_EN
        check("wrap rsp_carry", rsp_carry, 1'b1);
`endif
        tick();

        // Reset while in EXEC
        a_v[0] = rnd36(); b_v[0] = rnd36(); req_valid = 4'b0001;
        wait_accept(0, 8, "rst accept timeout");
        req_valid = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst rsp_valid", rsp_valid, 1'b0);
        check("rst busy", busy, 1'b0);
        n0 = resp_count;
        repeat (6) begin
            tick();
            check("rst no rsp", rsp_valid, 1'b0);
        end
        check("rst no response", resp_count - n0, 0);
        a_v[1] = rnd36(); b_v[1] = rnd36();
        req_valid = 4'b0011;
        #1;
        check("rst first grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Withdrawn request: pointer at 2, requesters 0,1,3 valid, 1 withdraws
        a_v[2] = rnd36(); b_v[2] = rnd36(); req_valid = 4'b0100;
        wait_accept(2, 8, "wd setup timeout");
        req_valid = '0;
        repeat (3) tick();
        base = grant_log.size();
        for (int i = 0; i < NREQ; i++) begin a_v[i] = rnd36(); b_v[i] = rnd36(); end
        req_valid = 4'b1011;
        wait_accept(3, 8, "wd grant3 timeout");
        req_valid = 4'b0001;
        wait_accept(0, 8, "wd grant0 timeout");
        req_valid = '0;
        repeat (4) tick();
        check("wd grant count", grant_log.size() - base, 2);
        if (grant_log.size() >= base + 2) begin
            check("wd first grant", grant_log[base], 3);
            check("wd second grant", grant_log[base + 1], 0);
        end
        seen1 = 1'b0;
        for (int k = base; k < grant_log.size(); k++) if (grant_log[k] == 1) seen1 = 1'b1;
        check("wd req1 never granted", seen1, 1'b0);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            #1;
            hs = req_valid & req_ready;
            tick();
            rst       = ($urandom_range(0, 149) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    a_v[i] = rnd36();
                    b_v[i] = rnd36();
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
